hazard_ctrl_unit: RTL and testbench

Parametrised successor to the pipeline hazard logic of the five-stage MIPS datapath. It arbitrates PC source, per-latch enables and flushes from one prioritised rule set. It adds a multi-cycle load-use stall FSM, a data-memory wait state, selectable branch-resolve stage and saturating performance counters. It sits between the decode/control outputs of each pipeline latch and the PC/latch controls in the datapath.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_perf_counter.sv | 30 +++
 rtl/hazard_ctrl_unit.sv | 217 +++++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
// Optional feature macro used by the top: HAZARD_FORWARD_EN.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    DWAIT  = 2'd2
  } hazard_state_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  // PC source mux selects driven onto pc_src.
  localparam logic [1:0] PC_NEXT   = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_JR     = 2'd3;

  // Width of the load-use bubble counter; LOAD_STALL is limited to 1..7.
  localparam int unsigned LstallCntW = 3;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with synchronous active-low clear.
module hazard_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Prioritised PC-source, latch-enable and flush control for the five-stage pipeline.
// Define HAZARD_FORWARD_EN to enable operand forwarding; otherwise every RAW hazard stalls.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned LOAD_STALL = 1,
  parameter bit          BR_MEM     = 1'b1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              rs_use_id,
  input  logic              rt_use_id,
  input  logic              jump_id,
  input  logic              jr_id,
  input  logic [REG_AW-1:0] wsel_ex,
  input  logic [REG_AW-1:0] wsel_mem,
  input  logic              wen_ex,
  input  logic              wen_mem,
  input  logic              dren_ex,
  input  logic              dmem_req_mem,
  input  logic              br_valid,
  input  logic              br_taken,
  output logic [1:0]        pc_src,
  output logic              enable_pc,
  output logic              enable_if_id,
  output logic              enable_id_ex,
  output logic              enable_ex_mem,
  output logic              enable_mem_wb,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [LstallCntW-1:0] LstallInit = LstallCntW'(LOAD_STALL - 1);

`ifdef HAZARD_FORWARD_EN
  localparam bit UseLstall = 1'b1;
`else
  localparam bit UseLstall = 1'b0;
`endif

  hazard_state_t         state_q, state_d;
  hazard_state_t         saved_q, saved_d;
  hazard_state_t         eff_state;
  logic [LstallCntW-1:0] count_q, count_d;

  logic mem_wait;
  logic br_redirect;
  logic rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
  logic lu_hazard, raw_ex, raw_mem, stall_req;
  logic flush_inc;

  assign mem_wait    = dmem_req_mem & ~dhit;
  assign br_redirect = br_valid & br_taken;
  // While waiting on memory the FSM behaves as the state it was in before the wait.
  assign eff_state   = (state_q == DWAIT) ? saved_q : state_q;

  assign rs_hit_ex  = rs_use_id && (wsel_ex != '0) && (rs_id == wsel_ex);
  assign rt_hit_ex  = rt_use_id && (wsel_ex != '0) && (rt_id == wsel_ex);
  assign rs_hit_mem = rs_use_id && (wsel_mem != '0) && (rs_id == wsel_mem);
  assign rt_hit_mem = rt_use_id && (wsel_mem != '0) && (rt_id == wsel_mem);

  assign lu_hazard = dren_ex & (rs_hit_ex | rt_hit_ex);
  assign raw_ex    = wen_ex & (rs_hit_ex | rt_hit_ex);
  assign raw_mem   = wen_mem & (rs_hit_mem | rt_hit_mem);

`ifdef HAZARD_FORWARD_EN
  assign stall_req = lu_hazard;
`else
  // Without forwarding the hold simply lasts as long as the dependency is visible.
  assign stall_req = lu_hazard | raw_ex | raw_mem;
`endif

  always_comb begin
    state_d       = state_q;
    saved_d       = saved_q;
    count_d       = count_q;
    pc_src        = PC_NEXT;
    enable_pc     = ihit;
    enable_if_id  = ihit;
    enable_id_ex  = ihit;
    enable_ex_mem = ihit | dhit;
    enable_mem_wb = ihit | dhit;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    flush_ex_mem  = 1'b0;
    flush_inc     = 1'b0;

    if (mem_wait) begin
      enable_pc     = 1'b0;
      enable_if_id  = 1'b0;
      enable_id_ex  = 1'b0;
      enable_ex_mem = 1'b0;
      enable_mem_wb = 1'b0;
      if (state_q != DWAIT) begin
        saved_d = state_q;
        state_d = DWAIT;
      end
    end else begin
      state_d = eff_state;
      if (br_redirect) begin
        pc_src       = PC_BRANCH;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = BR_MEM;
        flush_inc    = 1'b1;
        state_d      = RUN;
        count_d      = '0;
      end else if ((eff_state == LSTALL) || stall_req) begin
        enable_pc    = 1'b0;
        enable_if_id = 1'b0;
        flush_id_ex  = 1'b1;
        if (ihit) begin
          if (eff_state == LSTALL) begin
            // count holds the LSTALL bubbles still owed, including this one.
            if (count_q <= LstallCntW'(1)) begin
              state_d = RUN;
              count_d = '0;
            end else begin
              count_d = count_q - 1'b1;
            end
          end else if (UseLstall && (LOAD_STALL > 1)) begin
            state_d = LSTALL;
            count_d = LstallInit;
          end
        end
      end else if (ihit && (jump_id || jr_id)) begin
        pc_src      = jr_id ? PC_JR : PC_JUMP;
        flush_if_id = 1'b1;
        flush_inc   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= RUN;
      saved_q <= RUN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      count_q <= count_d;
    end
  end

`ifdef HAZARD_FORWARD_EN
  // Destination now in MEM/WB; a non-writing instruction is recorded as register 0.
  logic [REG_AW-1:0] wb_wsel_q, wb_wsel_d;
  fwd_sel_t          fwd_a_sel, fwd_b_sel;

  always_comb begin
    wb_wsel_d = wb_wsel_q;
    if (enable_mem_wb) begin
      wb_wsel_d = wen_mem ? wsel_mem : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wb_wsel_q <= '0;
    end else begin
      wb_wsel_q <= wb_wsel_d;
    end
  end

  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if ((rs_id != '0) && wen_mem && (rs_id == wsel_mem)) begin
      fwd_a_sel = FWD_EXMEM;
    end else if ((rs_id != '0) && (rs_id == wb_wsel_q)) begin
      fwd_a_sel = FWD_MEMWB;
    end
    if ((rt_id != '0) && wen_mem && (rt_id == wsel_mem)) begin
      fwd_b_sel = FWD_EXMEM;
    end else if ((rt_id != '0) && (rt_id == wb_wsel_q)) begin
      fwd_b_sel = FWD_MEMWB;
    end
  end

  assign fwd_a = fwd_a_sel;
  assign fwd_b = fwd_b_sel;
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

  hazard_perf_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk_i (CLK),
    .rst_ni(nRST),
    .inc_i (~enable_pc),
    .cnt_o (stall_cnt)
  );

  hazard_perf_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk_i (CLK),
    .rst_ni(nRST),
    .inc_i (flush_inc),
    .cnt_o (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed cycles push expectations, a monitor checks.
// Expected forwarding values follow HAZARD_FORWARD_EN when it is defined for the build.
module tb_hazard_ctrl_unit;

  localparam int unsigned RegAw = 5;
  localparam int unsigned CntW  = 32;
`ifdef HAZARD_FORWARD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             nRST;
  logic             ihit, dhit;
  logic [RegAw-1:0] rs_id, rt_id, wsel_ex, wsel_mem;
  logic             rs_use_id, rt_use_id, jump_id, jr_id;
  logic             wen_ex, wen_mem, dren_ex, dmem_req_mem, br_valid, br_taken;

  logic [1:0]      pc_src, fwd_a, fwd_b;
  logic            enable_pc, enable_if_id, enable_id_ex, enable_ex_mem, enable_mem_wb;
  logic            flush_if_id, flush_id_ex, flush_ex_mem;
  logic [CntW-1:0] stall_cnt, flush_cnt;

  logic [1:0]      b0_pc_src, b0_fwd_a, b0_fwd_b;
  logic            b0_en_pc, b0_en_if_id, b0_en_id_ex, b0_en_ex_mem, b0_en_mem_wb;
  logic            b0_fl_if_id, b0_fl_id_ex, b0_fl_ex_mem;
  logic [CntW-1:0] b0_stall_cnt, b0_flush_cnt;

  always #5 CLK = ~CLK;

  hazard_ctrl_unit #(
    .REG_AW(RegAw), .LOAD_STALL(2), .BR_MEM(1'b1), .CNT_W(CntW)
  ) u_dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .rs_id(rs_id), .rt_id(rt_id), .rs_use_id(rs_use_id), .rt_use_id(rt_use_id),
    .jump_id(jump_id), .jr_id(jr_id), .wsel_ex(wsel_ex), .wsel_mem(wsel_mem),
    .wen_ex(wen_ex), .wen_mem(wen_mem), .dren_ex(dren_ex), .dmem_req_mem(dmem_req_mem),
    .br_valid(br_valid), .br_taken(br_taken), .pc_src(pc_src),
    .enable_pc(enable_pc), .enable_if_id(enable_if_id), .enable_id_ex(enable_id_ex),
    .enable_ex_mem(enable_ex_mem), .enable_mem_wb(enable_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl_unit #(
    .REG_AW(RegAw), .LOAD_STALL(2), .BR_MEM(1'b0), .CNT_W(CntW)
  ) u_dut_b0 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .rs_id(rs_id), .rt_id(rt_id), .rs_use_id(rs_use_id), .rt_use_id(rt_use_id),
    .jump_id(jump_id), .jr_id(jr_id), .wsel_ex(wsel_ex), .wsel_mem(wsel_mem),
    .wen_ex(wen_ex), .wen_mem(wen_mem), .dren_ex(dren_ex), .dmem_req_mem(dmem_req_mem),
    .br_valid(br_valid), .br_taken(br_taken), .pc_src(b0_pc_src),
    .enable_pc(b0_en_pc), .enable_if_id(b0_en_if_id), .enable_id_ex(b0_en_id_ex),
    .enable_ex_mem(b0_en_ex_mem), .enable_mem_wb(b0_en_mem_wb),
    .flush_if_id(b0_fl_if_id), .flush_id_ex(b0_fl_id_ex), .flush_ex_mem(b0_fl_ex_mem),
    .fwd_a(b0_fwd_a), .fwd_b(b0_fwd_b), .stall_cnt(b0_stall_cnt), .flush_cnt(b0_flush_cnt)
  );

  typedef struct packed {
    logic [7:0]  tag;
    logic [1:0]  pc;
    logic [4:0]  en;
    logic [2:0]  fl;
    logic [2:0]  fl_b0;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic cmp(input string name, input logic [7:0] tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, tag, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      cmp("pc_src", mon_e.tag, 32'(pc_src), 32'(mon_e.pc));
      cmp("enables", mon_e.tag,
          32'({enable_pc, enable_if_id, enable_id_ex, enable_ex_mem, enable_mem_wb}),
          32'(mon_e.en));
      cmp("flushes", mon_e.tag, 32'({flush_if_id, flush_id_ex, flush_ex_mem}), 32'(mon_e.fl));
      cmp("flushes_br_id", mon_e.tag, 32'({b0_fl_if_id, b0_fl_id_ex, b0_fl_ex_mem}),
          32'(mon_e.fl_b0));
      cmp("fwd_a", mon_e.tag, 32'(fwd_a), 32'(mon_e.fa));
      cmp("fwd_b", mon_e.tag, 32'(fwd_b), 32'(mon_e.fb));
      cmp("stall_cnt", mon_e.tag, stall_cnt, mon_e.sc);
      cmp("flush_cnt", mon_e.tag, flush_cnt, mon_e.fc);
    end
  end

  // Push the expected response for the inputs currently applied, then advance one cycle.
  task automatic expect_cycle(input logic [7:0] tag, input logic [1:0] pc,
                              input logic [4:0] en, input logic [2:0] fl,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input logic [31:0] sc, input logic [31:0] fc);
    exp_t e;
    e.tag   = tag;
    e.pc    = pc;
    e.en    = en;
    e.fl    = fl;
    e.fl_b0 = {fl[2:1], 1'b0};
    e.fa    = fa;
    e.fb    = fb;
    e.sc    = sc;
    e.fc    = fc;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    ihit = 1'b1; dhit = 1'b0;
    rs_id = '0; rt_id = '0; rs_use_id = 1'b0; rt_use_id = 1'b0;
    jump_id = 1'b0; jr_id = 1'b0;
    wsel_ex = '0; wsel_mem = '0; wen_ex = 1'b0; wen_mem = 1'b0; dren_ex = 1'b0;
    dmem_req_mem = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
  endtask

  // lw to $r in ID/EX, consumer reading $r (rs) and $3 (rt) in IF/ID.
  task automatic load_in_ex(input logic [RegAw-1:0] r);
    dren_ex = 1'b1; wen_ex = 1'b1; wsel_ex = r;
    rs_id = r; rs_use_id = 1'b1; rt_id = 5'd3; rt_use_id = 1'b1;
  endtask

  // Same lw one stage later, consumer still held in IF/ID.
  task automatic load_in_mem(input logic [RegAw-1:0] r);
    wen_mem = 1'b1; wsel_mem = r;
    rs_id = r; rs_use_id = 1'b1; rt_id = 5'd3; rt_use_id = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    set_idle();
    ihit = 1'b0;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    expect_cycle(0, 2'd0, 5'b00000, 3'b000, 2'd0, 2'd0, 0, 0);
    nRST = 1'b1;

    set_idle();                                   // plain run
    expect_cycle(1, 2'd0, 5'b11111, 3'b000, 2'd0, 2'd0, 0, 0);
    set_idle(); load_in_ex(5'd8);                 // load-use detected
    expect_cycle(2, 2'd0, 5'b00111, 3'b010, 2'd0, 2'd0, 0, 0);
    set_idle(); load_in_mem(5'd8);                // second bubble
    expect_cycle(3, 2'd0, 5'b00111, 3'b010, Fwd ? 2'd1 : 2'd0, 2'd0, 1, 0);
    set_idle(); rs_id = 5'd8; rs_use_id = 1'b1;   // consumer released
    expect_cycle(4, 2'd0, 5'b11111, 3'b000, Fwd ? 2'd2 : 2'd0, 2'd0, 2, 0);

    set_idle(); br_valid = 1'b1; br_taken = 1'b1; // taken branch
    expect_cycle(5, 2'd1, 5'b11111, 3'b111, 2'd0, 2'd0, 2, 0);
    set_idle();
    expect_cycle(6, 2'd0, 5'b11111, 3'b000, 2'd0, 2'd0, 2, 1);
    set_idle(); load_in_ex(5'd8); br_valid = 1'b1; br_taken = 1'b1; // branch beats load-use
    expect_cycle(7, 2'd1, 5'b11111, 3'b111, 2'd0, 2'd0, 2, 1);
    set_idle();
    expect_cycle(8, 2'd0, 5'b11111, 3'b000, 2'd0, 2'd0, 2, 2);

    set_idle(); jump_id = 1'b1;
    expect_cycle(9, 2'd2, 5'b11111, 3'b100, 2'd0, 2'd0, 2, 2);
    set_idle(); jr_id = 1'b1;
    expect_cycle(10, 2'd3, 5'b11111, 3'b100, 2'd0, 2'd0, 2, 3);
    set_idle(); load_in_ex(5'd8); jump_id = 1'b1; // jump ignored while held
    expect_cycle(11, 2'd0, 5'b00111, 3'b010, 2'd0, 2'd0, 2, 4);
    set_idle(); load_in_mem(5'd8); jump_id = 1'b1;
    expect_cycle(12, 2'd0, 5'b00111, 3'b010, Fwd ? 2'd1 : 2'd0, 2'd0, 3, 4);
    set_idle();
    expect_cycle(13, 2'd0, 5'b11111, 3'b000, 2'd0, 2'd0, 4, 4);

    set_idle(); load_in_ex(5'd8);                 // load-use, then memory wait
    expect_cycle(14, 2'd0, 5'b00111, 3'b010, 2'd0, 2'd0, 4, 4);
    for (int i = 0; i < 3; i++) begin
      set_idle(); load_in_mem(5'd8); dmem_req_mem = 1'b1;
      expect_cycle(8'(15 + i), 2'd0, 5'b00000, 3'b000, Fwd ? 2'd1 : 2'd0, 2'd0,
                   32'(5 + i), 4);
    end
    set_idle(); load_in_mem(5'd8); dmem_req_mem = 1'b1; dhit = 1'b1; // resume bubble
    expect_cycle(18, 2'd0, 5'b00111, 3'b010, Fwd ? 2'd1 : 2'd0, 2'd0, 8, 4);
    set_idle();
    expect_cycle(19, 2'd0, 5'b11111, 3'b000, 2'd0, 2'd0, 9, 4);

    set_idle(); wen_mem = 1'b1; wsel_mem = 5'd9; rs_id = 5'd9;   // EX/MEM forward
    expect_cycle(20, 2'd0, 5'b11111, 3'b000, Fwd ? 2'd1 : 2'd0, 2'd0, 9, 4);
    set_idle(); wen_mem = 1'b1; wsel_mem = 5'd0; rt_id = 5'd9;   // $0 never forwards
    expect_cycle(21, 2'd0, 5'b11111, 3'b000, 2'd0, Fwd ? 2'd2 : 2'd0, 9, 4);

    set_idle();
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
